// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM states and
// the misalignment rule used when LSU_MISALIGN_TRAP_EN is defined.
package lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    RESP  = 2'd3
  } lsu_state_e;

  // Size 2'b11 is treated as a word, so any size with bit 1 set is a word.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    logic bad;
    bad = 1'b0;
    if (size[1])
      bad = (addr_lo != 2'b00);
    else if (size == SZ_HALF)
      bad = addr_lo[0];
    return bad;
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane steering: extracts and extends load data from a memory
// word and merges sub-word store data into the addressed little-endian lanes.
module lsu_lane_align
  import lsu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [1:0]        size,
  input  logic              is_unsigned,
  input  logic [1:0]        addr_lo,
  input  logic [DATA_W-1:0] word_in,
  input  logic [15:0]       store_data,
  output logic [DATA_W-1:0] load_data,
  output logic [DATA_W-1:0] merge_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic        sign_bit;

  always_comb begin
    case (addr_lo)
      2'd0:    byte_sel = word_in[7:0];
      2'd1:    byte_sel = word_in[15:8];
      2'd2:    byte_sel = word_in[23:16];
      default: byte_sel = word_in[31:24];
    endcase
    // Half lane follows addr[1] only, so an odd half address is forced down.
    half_sel = addr_lo[1] ? word_in[31:16] : word_in[15:0];

    sign_bit  = 1'b0;
    load_data = word_in;
    if (size == SZ_BYTE) begin
      sign_bit  = byte_sel[7] & ~is_unsigned;
      load_data = {{24{sign_bit}}, byte_sel};
    end else if (size == SZ_HALF) begin
      sign_bit  = half_sel[15] & ~is_unsigned;
      load_data = {{16{sign_bit}}, half_sel};
    end

    merge_data = word_in;
    if (size == SZ_BYTE) begin
      case (addr_lo)
        2'd0:    merge_data[7:0]   = store_data[7:0];
        2'd1:    merge_data[15:8]  = store_data[7:0];
        2'd2:    merge_data[23:16] = store_data[7:0];
        default: merge_data[31:24] = store_data[7:0];
      endcase
    end else if (size == SZ_HALF) begin
      if (addr_lo[1])
        merge_data[31:16] = store_data;
      else
        merge_data[15:0]  = store_data;
    end
  end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit with read-modify-write sub-word stores.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned half/word accesses instead of forcing alignment.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_rdata
);

  lsu_state_e        state_q, state_d;
  logic              write_q, write_d;
  logic [1:0]        size_q, size_d;
  logic              uns_q, uns_d;
  logic [1:0]        addr_lo_q, addr_lo_d;
  logic [15:0]       wdata_q, wdata_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] resp_rdata_q, resp_rdata_d;
  logic              resp_err_q, resp_err_d;

  logic              misalign;
  logic [DATA_W-1:0] load_data;
  logic [DATA_W-1:0] merge_data;

`ifdef LSU_MISALIGN_TRAP_EN
  assign misalign = is_misaligned(req_size, req_addr[1:0]);
`else
  assign misalign = 1'b0;
`endif

  lsu_lane_align #(.DATA_W(DATA_W)) u_align (
    .size        (size_q),
    .is_unsigned (uns_q),
    .addr_lo     (addr_lo_q),
    .word_in     (mem_rdata),
    .store_data  (wdata_q),
    .load_data   (load_data),
    .merge_data  (merge_data)
  );

  always_comb begin
    state_d      = state_q;
    write_d      = write_q;
    size_d       = size_q;
    uns_d        = uns_q;
    addr_lo_d    = addr_lo_q;
    wdata_d      = wdata_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          write_d   = req_write;
          size_d    = req_size;
          uns_d     = req_unsigned;
          addr_lo_d = req_addr[1:0];
          wdata_d   = req_wdata[15:0];
          if (misalign) begin
            resp_rdata_d = '0;
            resp_err_d   = 1'b1;
            state_d      = RESP;
          end else begin
            mem_addr_d = {req_addr[ADDR_W-1:2], 2'b00};
            if (req_write && req_size[1]) begin
              mem_wdata_d = req_wdata;
              state_d     = WRITE;
            end else begin
              state_d = READ;
            end
          end
        end
      end
      READ: begin
        if (write_q) begin
          mem_wdata_d = merge_data;
          state_d     = WRITE;
        end else begin
          resp_rdata_d = load_data;
          resp_err_d   = 1'b0;
          state_d      = RESP;
        end
      end
      WRITE: begin
        resp_rdata_d = '0;
        resp_err_d   = 1'b0;
        state_d      = RESP;
      end
      default: begin
        resp_err_d = 1'b0;
        state_d    = IDLE;
      end
    endcase
  end

  // Reset drops to IDLE immediately, so mem_write falls in the same instant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      write_q      <= 1'b0;
      size_q       <= SZ_WORD;
      uns_q        <= 1'b0;
      addr_lo_q    <= 2'b00;
      wdata_q      <= '0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      write_q      <= write_d;
      size_q       <= size_d;
      uns_q        <= uns_d;
      addr_lo_q    <= addr_lo_d;
      wdata_q      <= wdata_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == RESP);
  assign mem_read   = (state_q == READ);
  assign mem_write  = (state_q == WRITE);
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a small word-addressed memory model.
// Expectations follow LSU_MISALIGN_TRAP_EN when it is defined for the build.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_rdata;

  logic [31:0] mem [0:63] = '{default: 32'h0};
  logic        pre_en = 1'b0;
  logic [5:0]  pre_idx = '0;
  logic [31:0] pre_dat = '0;

  int n_chk  = 0;
  int n_pass = 0;
  logic [31:0] last_wr_addr;
  logic [31:0] last_wr_data;

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr[7:2]];

  always @(posedge clk) begin
    if (pre_en)
      mem[pre_idx] <= pre_dat;
    else if (mem_write)
      mem[mem_addr[7:2]] <= mem_wdata;
  end

  load_store_unit #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_write    (req_write),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_rdata    (mem_rdata)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp)
      n_pass++;
    else
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  // Issues one request from IDLE and follows it to its response.
  task automatic run_req(input string tag, input logic wr, input logic [1:0] sz,
                         input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                         input int exp_lat, input int exp_nrd, input int exp_nwr,
                         input logic [31:0] exp_rdata, input logic exp_err);
    int cyc, nrd, nwr, nboth;
    check({tag, ".ready"}, {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_write = wr; req_size = sz; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    @(posedge clk); #1;
    req_valid = 1'b0;
    cyc = 1; nrd = 0; nwr = 0; nboth = 0;
    while (!resp_valid && cyc < 8) begin
      if (mem_read) nrd++;
      if (mem_write) begin
        nwr++;
        last_wr_addr = mem_addr;
        last_wr_data = mem_wdata;
      end
      if (mem_read && mem_write) nboth++;
      @(posedge clk); #1;
      cyc++;
    end
    check({tag, ".lat"},   32'(cyc),   32'(exp_lat));
    check({tag, ".nrd"},   32'(nrd),   32'(exp_nrd));
    check({tag, ".nwr"},   32'(nwr),   32'(exp_nwr));
    check({tag, ".both"},  32'(nboth), 32'd0);
    check({tag, ".rdata"}, resp_rdata, exp_rdata);
    check({tag, ".err"},   {31'd0, resp_err}, {31'd0, exp_err});
    @(posedge clk); #1;
    check({tag, ".pulse"}, {31'd0, resp_valid}, 32'd0);
    check({tag, ".hold"},  resp_rdata, exp_rdata);
  endtask

  initial begin
    logic [6:0] acc, rsp;
    // Reset values, then preload word 0x10 with 0x8899AABB
    #2;
    check("rst.ready",  {31'd0, req_ready},  32'd1);
    check("rst.rvalid", {31'd0, resp_valid}, 32'd0);
    check("rst.err",    {31'd0, resp_err},   32'd0);
    check("rst.mrd",    {31'd0, mem_read},   32'd0);
    check("rst.mwr",    {31'd0, mem_write},  32'd0);
    check("rst.maddr",  mem_addr,   32'd0);
    check("rst.mwdata", mem_wdata,  32'd0);
    check("rst.rdata",  resp_rdata, 32'd0);
    pre_en = 1'b1; pre_idx = 6'd4; pre_dat = 32'h8899AABB;
    @(posedge clk); #1;
    pre_en = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_req("lb11",  1'b0, 2'b00, 1'b0, 32'h11, 32'h0, 2, 1, 0, 32'hFFFFFFAA, 1'b0);
    run_req("lbu11", 1'b0, 2'b00, 1'b1, 32'h11, 32'h0, 2, 1, 0, 32'h000000AA, 1'b0);
    run_req("lh12",  1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 2, 1, 0, 32'hFFFF8899, 1'b0);
    run_req("lhu12", 1'b0, 2'b01, 1'b1, 32'h12, 32'h0, 2, 1, 0, 32'h00008899, 1'b0);
    run_req("lb13",  1'b0, 2'b00, 1'b0, 32'h13, 32'h0, 2, 1, 0, 32'hFFFFFF88, 1'b0);
    run_req("lbu10", 1'b0, 2'b00, 1'b1, 32'h10, 32'h0, 2, 1, 0, 32'h000000BB, 1'b0);
    run_req("lw10",  1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 2, 1, 0, 32'h8899AABB, 1'b0);

    run_req("sh12",  1'b1, 2'b01, 1'b0, 32'h12, 32'h00001234, 3, 1, 1, 32'h0, 1'b0);
    check("sh12.waddr", last_wr_addr, 32'h10);
    check("sh12.wdata", last_wr_data, 32'h1234AABB);
    run_req("lw10b", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 2, 1, 0, 32'h1234AABB, 1'b0);

    run_req("sb11",  1'b1, 2'b00, 1'b0, 32'h11, 32'hFFFFFF55, 3, 1, 1, 32'h0, 1'b0);
    check("sb11.wdata", last_wr_data, 32'h123455BB);
    run_req("sw20",  1'b1, 2'b10, 1'b0, 32'h20, 32'hDEADBEEF, 2, 0, 1, 32'h0, 1'b0);
    check("sw20.waddr", last_wr_addr, 32'h20);
    run_req("lw20",  1'b0, 2'b11, 1'b0, 32'h20, 32'h0, 2, 1, 0, 32'hDEADBEEF, 1'b0);

`ifdef LSU_MISALIGN_TRAP_EN
    run_req("lw22",  1'b0, 2'b10, 1'b0, 32'h22, 32'h0, 1, 0, 0, 32'h0, 1'b1);
    run_req("lh21",  1'b0, 2'b01, 1'b0, 32'h21, 32'h0, 1, 0, 0, 32'h0, 1'b1);
    run_req("sw22",  1'b1, 2'b10, 1'b0, 32'h22, 32'h11111111, 1, 0, 0, 32'h0, 1'b1);
`else
    run_req("lw22",  1'b0, 2'b10, 1'b0, 32'h22, 32'h0, 2, 1, 0, 32'hDEADBEEF, 1'b0);
    run_req("lh21",  1'b0, 2'b01, 1'b0, 32'h21, 32'h0, 2, 1, 0, 32'hFFFFBEEF, 1'b0);
    run_req("sw22",  1'b1, 2'b10, 1'b0, 32'h22, 32'h11111111, 2, 0, 1, 32'h0, 1'b0);
    check("sw22.waddr", last_wr_addr, 32'h20);
    pre_en = 1'b1; pre_idx = 6'd8; pre_dat = 32'hDEADBEEF;
    @(posedge clk); #1;
    pre_en = 1'b0;
`endif
    check("mem20", mem[8], 32'hDEADBEEF);

    // Reset asserted while a byte store sits in WRITE
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = 32'h10; req_wdata = 32'h00000077;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("rstw.read", {31'd0, mem_read}, 32'd1);
    @(posedge clk); #1;
    check("rstw.write", {31'd0, mem_write}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("rstw.ready",  {31'd0, req_ready},  32'd1);
    check("rstw.mwr",    {31'd0, mem_write},  32'd0);
    check("rstw.rvalid", {31'd0, resp_valid}, 32'd0);
    check("rstw.maddr",  mem_addr, 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("rstw.mem", mem[4], 32'h123455BB);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rstw.rvalid2", {31'd0, resp_valid}, 32'd0);
    check("rstw.idle",    {31'd0, req_ready},  32'd1);

    // Back-to-back loads with req_valid held high
    req_valid = 1'b1; req_write = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
    req_addr = 32'h10; req_wdata = 32'h0;
    for (int i = 0; i < 7; i++) begin
      acc[i] = req_ready;
      rsp[i] = resp_valid;
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    check("b2b.accept", {25'd0, acc}, {25'd0, 7'b1001001});
    check("b2b.resp",   {25'd0, rsp}, {25'd0, 7'b0100100});
    repeat (3) @(posedge clk);
    #1;
    check("b2b.rdata", resp_rdata, 32'h123455BB);
    check("b2b.idle",  {31'd0, req_ready}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, meaning the byte-address width of request and memory ports.
REQ-002 SHALL have parameter DATA_W, default 32, meaning the data width; only 32 is supported.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port req_valid  input  1  request present.
REQ-006 SHALL have port req_ready  output  1  unit can accept a request.
REQ-007 SHALL have port req_write  input  1  1 = store, 0 = load.
REQ-008 SHALL have port req_size  input  2  00 byte, 01 half, 10 word, 11 treated as word.
REQ-009 SHALL have port req_unsigned  input  1  zero-extend loads when 1, sign-extend when 0.
REQ-010 SHALL have port req_addr  input  ADDR_W  byte address.
REQ-011 SHALL have port req_wdata  input  DATA_W  store data, right-aligned.
REQ-012 SHALL have port resp_valid  output  1  one-cycle completion pulse.
REQ-013 SHALL have port resp_rdata  output  DATA_W  extended load data; 0 for stores.
REQ-014 SHALL have port resp_err  output  1  misalignment error (see Configuration).
REQ-015 SHALL have ports mem_addr (output, ADDR_W), mem_wdata (output, DATA_W), mem_read (output, 1), mem_write (output, 1), mem_rdata (input, DATA_W), driving the word-addressed data memory, whose read is combinational and whose write commits on the clk edge.

Function
REQ-016 SHALL implement FSM states IDLE, READ, WRITE, RESP; req_ready = 1 only in IDLE.
REQ-017 IDLE: a request is accepted on an edge with req_valid && req_ready; fields are captured; next state READ for loads and byte/half stores, WRITE for word stores, RESP on misalignment error.
REQ-018 READ: mem_read = 1, mem_addr = {addr[ADDR_W-1:2], 2'b00}; mem_rdata is captured at the edge; next state RESP for loads, WRITE for stores.
REQ-019 WRITE: mem_write = 1, with mem_wdata = captured word with addressed lanes replaced (read-modify-write) for sub-word stores, or req_wdata for word stores; next state RESP.
REQ-020 RESP: resp_valid = 1 for exactly one cycle; next state IDLE unconditionally, with no response backpressure.
REQ-021 Latency with accept cycle N: load RESP in N+2; word store RESP in N+2; byte/half store RESP in N+3; error RESP in N+1.
REQ-022 Lanes SHALL be little-endian: byte lane = addr[1:0]; half lane = addr[1] (bytes 0-1 or 2-3).
REQ-023 Loads SHALL place the selected lane at bits [7:0] or [15:0] and extend to 32 bits per req_unsigned; word loads SHALL pass through unchanged.
REQ-024 mem_read and mem_write SHALL never be asserted in the same cycle and SHALL be 0 outside READ and WRITE respectively.
REQ-025 mem_addr and mem_wdata SHALL hold their last driven values when idle; resp_rdata SHALL hold until the next RESP.
REQ-026 req_valid asserted outside IDLE SHALL be ignored; the requester holds it until accepted.

Reset
REQ-027 rst_n low SHALL immediately force IDLE, req_ready = 1, resp_valid = 0, resp_err = 0, mem_read = 0, mem_write = 0, mem_addr = 0, mem_wdata = 0, resp_rdata = 0.
REQ-028 Reset mid-operation SHALL drop the in-flight request without a response; no memory write SHALL occur once rst_n is low.

Configuration
REQ-029 With LSU_MISALIGN_TRAP_EN defined: half with addr[0] = 1, or word with addr[1:0] != 0, SHALL perform no memory access and SHALL give RESP with resp_err = 1 and resp_rdata = 0.
REQ-030 Without LSU_MISALIGN_TRAP_EN: unused low address bits SHALL be ignored (forced alignment), and resp_err SHALL be tied 0.

Structure
REQ-031 Package lsu_pkg SHALL hold the size encodings (SZ_BYTE, SZ_HALF, SZ_WORD) and the FSM state enum.
REQ-032 Sub-module lsu_lane_align SHALL be combinational and SHALL perform load extract/extend and store lane merge.

Verification
REQ-033 Word 0x0000_0010 holds 0x8899AABB; lb at addr 0x11 -> resp_rdata 0xFFFFFFAA in N+2; lbu -> 0x000000AA.
REQ-034 Same word; sh of 0x1234 at addr 0x12 -> READ then WRITE with mem_wdata 0x1234AABB; RESP in N+3; a later lw returns 0x1234AABB.
REQ-035 sw of 0xDEADBEEF at addr 0x20 -> mem_write for exactly one cycle at mem_addr 0x20, no mem_read; RESP in N+2.
REQ-036 With the macro, lw at addr 0x22 -> no mem_read/mem_write, resp_err = 1 in N+1; without it -> a normal lw of word 0x20.
REQ-037 rst_n driven low during WRITE of a sub-word store -> memory unchanged, no resp_valid, req_ready = 1 immediately.
REQ-038 Back-to-back requests with req_valid held high -> each accepted only in IDLE, the next accept occurring in the cycle after RESP.
